// File: rtl/corr_window_capture_if.sv
// Bus bundle between the window sequencer, the counter block and the readout logic.
// With CORR_WINDOW_DERIVED_EN defined, the derived union/neither counts are added.
interface corr_window_capture_if #(
  parameter int unsigned TIME_W      = 8,
  parameter int unsigned WINDOWIDX_W = 16
);
  logic                   i_cg;
  logic [TIME_W-1:0]      i_windowLength;
  logic                   o_cg;
  logic                   o_zeroCounts;
  logic [TIME_W-1:0]      i_countX;
  logic [TIME_W-1:0]      i_countY;
  logic [TIME_W-1:0]      i_countIsect;
  logic [TIME_W-1:0]      i_countSymdiff;
  logic                   o_valid;
  logic                   i_ready;
  logic [TIME_W-1:0]      o_countX;
  logic [TIME_W-1:0]      o_countY;
  logic [TIME_W-1:0]      o_countIsect;
  logic [TIME_W-1:0]      o_countSymdiff;
  logic [TIME_W-1:0]      o_windowLength;
  logic [WINDOWIDX_W-1:0] o_windowIdx;
  logic                   o_overrun;
  logic                   i_clrOverrun;
`ifdef CORR_WINDOW_DERIVED_EN
  logic [TIME_W:0]        o_countUnion;
  logic [TIME_W:0]        o_countNeither;
`endif

  modport slave (
    input  i_cg, i_windowLength, i_countX, i_countY, i_countIsect, i_countSymdiff,
           i_ready, i_clrOverrun,
    output o_cg, o_zeroCounts, o_valid, o_countX, o_countY, o_countIsect,
           o_countSymdiff, o_windowLength, o_windowIdx, o_overrun
`ifdef CORR_WINDOW_DERIVED_EN
           , o_countUnion, o_countNeither
`endif
  );

  modport master (
    output i_cg, i_windowLength, i_countX, i_countY, i_countIsect, i_countSymdiff,
           i_ready, i_clrOverrun,
    input  o_cg, o_zeroCounts, o_valid, o_countX, o_countY, o_countIsect,
           o_countSymdiff, o_windowLength, o_windowIdx, o_overrun
`ifdef CORR_WINDOW_DERIVED_EN
           , o_countUnion, o_countNeither
`endif
  );
endinterface

// File: rtl/corr_window_capture.sv
// Window sequencer for the rectangular-window counter block plus a one-entry result holding register.
// Optional derived outputs (union, neither) are built when CORR_WINDOW_DERIVED_EN is defined.
module corr_window_capture #(
  parameter int unsigned TIME_W      = 8,
  parameter int unsigned WINDOWIDX_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  corr_window_capture_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  state_t                 state_q, state_d;
  logic [TIME_W-1:0]      pos_q, pos_d;
  logic [TIME_W-1:0]      len_q, len_d;
  logic [WINDOWIDX_W-1:0] win_cnt_q;
  logic                   valid_q, overrun_q;
  logic [TIME_W-1:0]      hold_x_q, hold_y_q, hold_isect_q, hold_symdiff_q, hold_len_q;
  logic [WINDOWIDX_W-1:0] hold_idx_q;
  logic                   capture_c, load_c;

  // State, strobe position and window length registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
    end
  end

  // Next state and counter-block controls decoded from the state register
  always_comb begin
    state_d          = state_q;
    pos_d            = pos_q;
    len_d            = len_q;
    bus.o_cg         = 1'b0;
    bus.o_zeroCounts = 1'b1;
    case (state_q)
      IDLE: begin
        len_d = bus.i_windowLength;
        pos_d = '0;
        if (bus.i_windowLength != '0) state_d = RUN;
      end
      RUN: begin
        bus.o_zeroCounts = 1'b0;
        bus.o_cg         = bus.i_cg;
        if (bus.i_cg) begin
          if (pos_q == len_q - TIME_W'(1)) begin
            state_d = CAPTURE;
            pos_d   = '0;
          end else begin
            pos_d = pos_q + TIME_W'(1);
          end
        end
      end
      CAPTURE: begin
        len_d   = bus.i_windowLength;
        pos_d   = '0;
        state_d = (bus.i_windowLength != '0) ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign capture_c = (state_q == CAPTURE);
  // Load when empty or when the consumer drains the entry in the same cycle
  assign load_c    = capture_c && (!valid_q || bus.i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_cnt_q      <= '0;
      valid_q        <= 1'b0;
      overrun_q      <= 1'b0;
      hold_x_q       <= '0;
      hold_y_q       <= '0;
      hold_isect_q   <= '0;
      hold_symdiff_q <= '0;
      hold_len_q     <= '0;
      hold_idx_q     <= '0;
    end else begin
      if (capture_c) win_cnt_q <= win_cnt_q + WINDOWIDX_W'(1);
      if (load_c) begin
        valid_q        <= 1'b1;
        hold_x_q       <= bus.i_countX;
        hold_y_q       <= bus.i_countY;
        hold_isect_q   <= bus.i_countIsect;
        hold_symdiff_q <= bus.i_countSymdiff;
        hold_len_q     <= len_q;
        hold_idx_q     <= win_cnt_q;
      end else if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end
      if (capture_c && !load_c) overrun_q <= 1'b1;
      else if (bus.i_clrOverrun) overrun_q <= 1'b0;
    end
  end

  assign bus.o_valid        = valid_q;
  assign bus.o_overrun      = overrun_q;
  assign bus.o_countX       = hold_x_q;
  assign bus.o_countY       = hold_y_q;
  assign bus.o_countIsect   = hold_isect_q;
  assign bus.o_countSymdiff = hold_symdiff_q;
  assign bus.o_windowLength = hold_len_q;
  assign bus.o_windowIdx    = hold_idx_q;

`ifdef CORR_WINDOW_DERIVED_EN
  logic [TIME_W:0] union_c, neither_c;
  logic [TIME_W:0] hold_union_q, hold_neither_q;

  assign union_c   = {1'b0, bus.i_countIsect} + {1'b0, bus.i_countSymdiff};
  assign neither_c = {1'b0, len_q} - union_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_union_q   <= '0;
      hold_neither_q <= '0;
    end else if (load_c) begin
      hold_union_q   <= union_c;
      hold_neither_q <= neither_c;
    end
  end

  assign bus.o_countUnion   = hold_union_q;
  assign bus.o_countNeither = hold_neither_q;
`endif

endmodule

// File: tb/tb_corr_window_capture.sv
// Randomized self-checking bench for corr_window_capture against a window-level reference model.
module tb_corr_window_capture;
  localparam int unsigned TIME_W      = 8;
  localparam int unsigned WINDOWIDX_W = 16;
`ifdef CORR_WINDOW_DERIVED_EN
  localparam int unsigned DW = 5*TIME_W + WINDOWIDX_W + 2*(TIME_W+1);
`else
  localparam int unsigned DW = 5*TIME_W + WINDOWIDX_W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  corr_window_capture_if #(.TIME_W(TIME_W), .WINDOWIDX_W(WINDOWIDX_W)) bus ();
  corr_window_capture #(.TIME_W(TIME_W), .WINDOWIDX_W(WINDOWIDX_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  // Stand-in for the counter block: clear has priority over gated increment
  logic x_bit = 1'b0, y_bit = 1'b0;
  logic [TIME_W-1:0] cx = '0, cy = '0, ci = '0, cs = '0;
  always @(posedge clk) begin
    if (bus.o_zeroCounts) begin
      cx <= '0; cy <= '0; ci <= '0; cs <= '0;
    end else if (bus.o_cg) begin
      cx <= cx + TIME_W'(x_bit);
      cy <= cy + TIME_W'(y_bit);
      ci <= ci + TIME_W'(x_bit & y_bit);
      cs <= cs + TIME_W'(x_bit ^ y_bit);
    end
  end
  assign bus.i_countX       = cx;
  assign bus.i_countY       = cy;
  assign bus.i_countIsect   = ci;
  assign bus.i_countSymdiff = cs;

  typedef struct { int x; int y; int i; int s; int len; int idx; } rec_t;

  int   n_checks = 0, n_fail = 0;
  // Reference: a window is the next L accepted strobes; each window end costs one dead cycle
  bit   m_active, m_dead, m_valid, m_ovr;
  int   m_len, m_n, m_idx;
  rec_t m_acc, m_pend, m_held;

  task automatic model_reset();
    m_active = 0; m_dead = 0; m_valid = 0; m_ovr = 0;
    m_len = 0; m_n = 0; m_idx = 0;
    m_acc = '{default: 0}; m_pend = '{default: 0}; m_held = '{default: 0};
  endtask

  function automatic logic [3:0] exp_ctrl();
    bit open_win = m_active && !m_dead;
    return {open_win && bus.i_cg, !open_win, m_valid, m_ovr};
  endfunction

  function automatic logic [3:0] obs_ctrl();
    return {bus.o_cg, bus.o_zeroCounts, bus.o_valid, bus.o_overrun};
  endfunction

  function automatic logic [DW-1:0] exp_data();
    logic [DW-1:0] d;
    d = {TIME_W'(m_held.x), TIME_W'(m_held.y), TIME_W'(m_held.i), TIME_W'(m_held.s),
         TIME_W'(m_held.len), WINDOWIDX_W'(m_held.idx)
`ifdef CORR_WINDOW_DERIVED_EN
         , (TIME_W+1)'(m_held.i + m_held.s), (TIME_W+1)'(m_held.len - (m_held.i + m_held.s))
`endif
        };
    return d;
  endfunction

  function automatic logic [DW-1:0] obs_data();
    logic [DW-1:0] d;
    d = {bus.o_countX, bus.o_countY, bus.o_countIsect, bus.o_countSymdiff,
         bus.o_windowLength, bus.o_windowIdx
`ifdef CORR_WINDOW_DERIVED_EN
         , bus.o_countUnion, bus.o_countNeither
`endif
        };
    return d;
  endfunction

  // Apply inputs just after the falling edge; outputs are then settled 1 time unit later
  task automatic drive(input bit cg, input int len, input bit rdy, input bit clr);
    bus.i_cg = cg;
    bus.i_windowLength = TIME_W'(len);
    bus.i_ready = rdy;
    bus.i_clrOverrun = clr;
    x_bit = 1'($urandom_range(0, 1));
    y_bit = 1'($urandom_range(0, 1));
    #1;
  endtask

  // Cross the rising edge and advance the reference by one cycle
  task automatic advance();
    bit cap, load;
    @(posedge clk);
    cap  = m_dead;
    load = cap && (!m_valid || bus.i_ready);
    if (load) begin
      m_held = m_pend; m_valid = 1;
    end else if (m_valid && bus.i_ready) begin
      m_valid = 0;
    end
    if (cap && !load) m_ovr = 1;
    else if (bus.i_clrOverrun) m_ovr = 0;
    if (m_dead || !m_active) begin
      m_dead = 0;
      m_len = int'(bus.i_windowLength);
      m_active = (m_len != 0);
      m_n = 0;
      m_acc = '{default: 0};
    end else if (bus.i_cg) begin
      m_n++;
      m_acc.x += int'(x_bit);
      m_acc.y += int'(y_bit);
      m_acc.i += int'(x_bit & y_bit);
      m_acc.s += int'(x_bit ^ y_bit);
      if (m_n == m_len) begin
        m_pend = m_acc;
        m_pend.len = m_len;
        m_pend.idx = m_idx;
        m_idx = (m_idx + 1) % (1 << WINDOWIDX_W);
        m_dead = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 0, 1'b1, 1'b0);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        n_fail++; $display("FAIL reset_ctrl cyc=%0d got=%b exp=%b", k, obs_ctrl(), exp_ctrl());
      end
      n_checks++;
      if (obs_data() !== exp_data()) begin
        n_fail++; $display("FAIL reset_data cyc=%0d got=%h exp=%h", k, obs_data(), exp_data());
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_l0();
    for (int k = 0; k < 14; k++) begin
      drive(1'($urandom_range(0, 1)) | (k >= 6), (k < 6) ? 0 : 3, 1'b1, 1'b0);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        n_fail++; $display("FAIL idle_l0_ctrl cyc=%0d got=%b exp=%b", k, obs_ctrl(), exp_ctrl());
      end
      n_checks++;
      if (obs_data() !== exp_data()) begin
        n_fail++; $display("FAIL idle_l0_data cyc=%0d got=%h exp=%h", k, obs_data(), exp_data());
      end
      advance();
    end
  endtask

  task automatic test_steady_l4();
    for (int k = 0; k < 25; k++) begin
      drive(1'b1, 4, 1'b1, 1'b0);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        n_fail++; $display("FAIL steady_ctrl cyc=%0d got=%b exp=%b", k, obs_ctrl(), exp_ctrl());
      end
      n_checks++;
      if (obs_data() !== exp_data()) begin
        n_fail++; $display("FAIL steady_data cyc=%0d got=%h exp=%h", k, obs_data(), exp_data());
      end
      advance();
    end
  endtask

  task automatic test_overrun();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2, (k >= 16), (k == 9) || (k == 14));
      n_checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        n_fail++; $display("FAIL overrun_ctrl cyc=%0d got=%b exp=%b", k, obs_ctrl(), exp_ctrl());
      end
      n_checks++;
      if (obs_data() !== exp_data()) begin
        n_fail++; $display("FAIL overrun_data cyc=%0d got=%h exp=%h", k, obs_data(), exp_data());
      end
      advance();
    end
  endtask

  task automatic test_len_change();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, (k < 2) ? 4 : 2, 1'b1, 1'b1);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        n_fail++; $display("FAIL len_change_ctrl cyc=%0d got=%b exp=%b", k, obs_ctrl(), exp_ctrl());
      end
      n_checks++;
      if (obs_data() !== exp_data()) begin
        n_fail++; $display("FAIL len_change_data cyc=%0d got=%h exp=%h", k, obs_data(), exp_data());
      end
      advance();
    end
  endtask

  task automatic test_random();
    int len = 3;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) len = int'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 3) != 0), len, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 5) == 0));
      n_checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        n_fail++; $display("FAIL random_ctrl cyc=%0d got=%b exp=%b", k, obs_ctrl(), exp_ctrl());
      end
      n_checks++;
      if (obs_data() !== exp_data()) begin
        n_fail++; $display("FAIL random_data cyc=%0d got=%h exp=%h", k, obs_data(), exp_data());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    while (!(m_valid && m_active && !m_dead) && budget < 40) begin
      drive(1'b1, 3, 1'b0, 1'b0);
      advance();
      budget++;
    end
    n_checks++;
    if (budget >= 40) begin
      n_fail++; $display("FAIL reset_mid_setup got=timeout exp=valid_in_run");
    end
    drive(1'b1, 3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_ctrl() !== exp_ctrl()) begin
      n_fail++; $display("FAIL reset_mid_ctrl got=%b exp=%b", obs_ctrl(), exp_ctrl());
    end
    n_checks++;
    if (obs_data() !== exp_data()) begin
      n_fail++; $display("FAIL reset_mid_data got=%h exp=%h", obs_data(), exp_data());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 3, 1'b1, 1'b0);
      n_checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        n_fail++; $display("FAIL after_reset_ctrl cyc=%0d got=%b exp=%b", k, obs_ctrl(), exp_ctrl());
      end
      n_checks++;
      if (obs_data() !== exp_data()) begin
        n_fail++; $display("FAIL after_reset_data cyc=%0d got=%h exp=%h", k, obs_data(), exp_data());
      end
      advance();
    end
  endtask

  initial begin
    bus.i_cg = 1'b0;
    bus.i_windowLength = '0;
    bus.i_ready = 1'b0;
    bus.i_clrOverrun = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_l0();
    test_steady_l4();
    test_overrun();
    test_len_change();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/corr_window_capture.md
# corr_window_capture

Window sequencer and result capture stage that sits directly downstream of the correlator's rectangular-window counter block. It counts `i_cg` strobes to define fixed-length windows, drives that block's gated strobe and zero-counts inputs, and latches its four counts (X, Y, intersection, symmetric difference) at each window end. The captured counts go into a single-entry valid/ready holding register for the readout logic.

## Interface
Parameters:
- `TIME_W`, 8: width of counts and of the window length; must match the counter block.
- `WINDOWIDX_W`, 16: width of the window index.

Ports:
- `i_clk`  input  1  clock.
- `i_rst_n`  input  1  reset; asynchronous, active-low.
- `i_cg`  input  1  sample strobe from the sampler.
- `i_windowLength`  input  TIME_W  window length in strobes. 0 disables windowing.
- `o_cg`  output  1  gated strobe to the counter block.
- `o_zeroCounts`  output  1  clear to the counter block.
- `i_countX`, `i_countY`, `i_countIsect`, `i_countSymdiff`  input  TIME_W each  counts from the counter block.
- `o_valid`  output  1  holding register full.
- `i_ready`  input  1  consumer accepts the result.
- `o_countX`, `o_countY`, `o_countIsect`, `o_countSymdiff`  output  TIME_W each  held counts.
- `o_windowLength`  output  TIME_W  length of the held window.
- `o_windowIdx`  output  WINDOWIDX_W  index of the held window.
- `o_overrun`  output  1  sticky flag: a result was discarded.
- `i_clrOverrun`  input  1  synchronous clear of `o_overrun`.

## Operation
- States: IDLE, RUN, CAPTURE. `o_cg` and `o_zeroCounts` decode from the state register.
  - IDLE: `o_zeroCounts`=1, `o_cg`=0.
  - RUN: `o_zeroCounts`=0, `o_cg`=`i_cg`. This is the only combinational input-to-output path.
  - CAPTURE: `o_zeroCounts`=1, `o_cg`=0.
- Window length L:
  - L is a private register loaded from `i_windowLength` in IDLE and in CAPTURE.
  - Changes to `i_windowLength` during RUN have no effect until the next window.
- Transitions:
  - IDLE goes to RUN when the sampled L≠0. Strobe position `pos` is set to 0.
  - In RUN, each `i_cg` increments `pos`. `i_cg` with `pos`==L-1 moves to CAPTURE.
  - CAPTURE always lasts exactly one cycle. It goes to RUN with `pos`=0 if the new L≠0, else to IDLE.
- Capture, during the CAPTURE cycle:
  - A window counter of WINDOWIDX_W bits increments and wraps. It increments for every completed window, including discarded ones.
  - If `o_valid`=0, or `i_ready`=1 in the same cycle, the holding register loads `i_count*`, L and the index.
  - Otherwise the result is discarded and `o_overrun` sets.
- Handshake:
  - A transfer occurs on any cycle with `o_valid` & `i_ready`.
  - Held data stays stable while `o_valid`=1.
  - `o_valid` clears after a transfer unless a new load occurs in the same cycle.
- `o_overrun`: set has priority over `i_clrOverrun`.
- Reset values:
  - IDLE state; `o_zeroCounts`=1; `o_cg`=0; `o_valid`=0; `o_overrun`=0.
  - All held counts, `o_windowLength` and `o_windowIdx` = 0.
  - `pos`, L and the window counter = 0.

## Timing
- The counter block applies clear with priority over increment. Its counts are final in the cycle after the last strobe of the window.
- Latency:
  - CAPTURE is the cycle after the final strobe.
  - `o_valid` rises the cycle after CAPTURE, i.e. 2 cycles after the final strobe.
- Dead cycle: an `i_cg` during CAPTURE is not forwarded and not counted in `pos`.
- L=1: every forwarded strobe ends a window. At most one strobe per 2 cycles is counted.
- Reset asserted mid-window: all state returns to reset values immediately. The partial window is lost and the counter block is cleared via `o_zeroCounts`.
- Reset deassertion: L is sampled on the first clock edge after release.

## Configuration
- `CORR_WINDOW_DERIVED_EN` defined adds outputs, registered alongside the held counts:
  - `o_countUnion` (TIME_W+1) = Isect + Symdiff.
  - `o_countNeither` (TIME_W+1) = L − union.
- Arithmetic is unsigned and zero-extended. Union never exceeds L.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- L=4, `i_cg` held 1, ready held 1:
  - `o_cg` is high for 4 cycles, then low for 1 cycle with `o_zeroCounts`=1.
  - `o_valid` pulses every 5 cycles, with idx 0,1,2…
  - Counts equal the X/Y pattern sums.
- L=0 after reset:
  - Stays in IDLE with `o_zeroCounts`=1 and `o_cg`=0.
  - Setting L=3 gives first `o_cg` forwarding 1 cycle later.
- Ready held 0, L=2, strobes every cycle:
  - First window is held.
  - Second window sets `o_overrun`=1; the held data is unchanged (idx 0) while `o_windowIdx` counter advances.
  - `i_clrOverrun`=1 on the next overrun cycle leaves `o_overrun`=1.
- Change `i_windowLength` 4→2 mid-window: the current window still spans 4 strobes and the next spans 2. `o_windowLength` reports 4, then 2.
- Assert `i_rst_n`=0 mid-RUN with `o_valid`=1: all outputs go to reset values asynchronously, and idx restarts at 0.
- With `CORR_WINDOW_DERIVED_EN`: L=8, isect=3, symdiff=2 → `o_countUnion`=5, `o_countNeither`=3.
